// File: rtl/lane_grant_if.sv
// Bus between a requester and the lane grant scheduler.
// The requester drives enable, lane requests and burst length; the scheduler returns the grant.
interface lane_grant_if #(
  parameter int unsigned LEN_W = 4
);
  logic             en;
  logic [6:0]       req;
  logic [LEN_W-1:0] burst_len;
  logic [2:0]       sel;
  logic             sel_val;
  logic [6:0]       grant;
  logic             last;

  modport master (
    output en, req, burst_len,
    input  sel, sel_val, grant, last
  );

  modport slave (
    input  en, req, burst_len,
    output sel, sel_val, grant, last
  );
endinterface

// File: rtl/lane_grant_scheduler.sv
// Round-robin burst scheduler for seven lanes: grants one lane for burst_len+1 cycles,
// then rotates priority past that lane, chaining bursts back-to-back when requests remain.
module lane_grant_scheduler #(
  parameter int unsigned LEN_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  lane_grant_if.slave bus
);
  localparam int unsigned LANES = 7;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic             val_q, val_n;
  logic [LANES-1:0] grant_q, grant_n;
  logic             last_q, last_n;

  logic             burst_end;
  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] win;
  logic             win_found;
  logic [SEL_W-1:0] idx;
  logic             launch;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] p);
    return (p == SEL_W'(LANES - 1)) ? SEL_W'(0) : p + SEL_W'(1);
  endfunction

  function automatic logic [SEL_W-1:0] lane_add(input logic [SEL_W-1:0] a,
                                                input logic [SEL_W-1:0] b);
    logic [SEL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (SEL_W+1)'(LANES)) s = s - (SEL_W+1)'(LANES);
    return s[SEL_W-1:0];
  endfunction

  // On the final burst cycle the scan already starts past the lane just served.
  always_comb begin
    burst_end = (state == BURST) && (cnt == '0);
    base      = burst_end ? wrap_inc(sel_q) : ptr;
    win       = base;
    win_found = 1'b0;
    idx       = base;
    for (int i = 0; i < int'(LANES); i++) begin
      idx = lane_add(base, SEL_W'(i));
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
    launch = bus.en && win_found;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    sel_n   = sel_q;
    val_n   = val_q;
    last_n  = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_n = BURST;
          sel_n   = win;
          val_n   = 1'b1;
          cnt_n   = bus.burst_len;
          last_n  = (bus.burst_len == '0);
        end else begin
          val_n   = 1'b0;
        end
      end
      BURST: begin
        if (cnt != '0) begin
          cnt_n  = cnt - LEN_W'(1);
          last_n = (cnt == LEN_W'(1));
        end else begin
          ptr_n = wrap_inc(sel_q);
          if (launch) begin
            sel_n  = win;
            val_n  = 1'b1;
            cnt_n  = bus.burst_len;
            last_n = (bus.burst_len == '0);
          end else begin
            state_n = IDLE;
            val_n   = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        val_n   = 1'b0;
      end
    endcase
    grant_n = val_n ? (LANES'(1) << sel_n) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      sel_q   <= '0;
      val_q   <= 1'b0;
      grant_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      sel_q   <= sel_n;
      val_q   <= val_n;
      grant_q <= grant_n;
      last_q  <= last_n;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.sel_val = val_q;
  assign bus.grant   = grant_q;
  assign bus.last    = last_q;
endmodule

// File: tb/tb_lane_grant_scheduler.sv
// Directed bench for lane_grant_scheduler: a vector table for rotation, wrap and length
// behaviour, plus hand-written enable-drop and reset-mid-burst sequences.
module tb_lane_grant_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  lane_grant_if #(.LEN_W(4)) bus ();

  lane_grant_scheduler #(.LEN_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [6:0] req;
    logic [3:0] bl;
    logic [2:0] sel;
    logic       val;
    logic [6:0] grant;
    logic       last;
  } vec_t;

  vec_t vecs[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle and sample the registered outputs just after the edge.
  task automatic drive(input logic r, input logic e, input logic [6:0] q, input logic [3:0] b);
    @(negedge clk);
    reset         = r;
    bus.en        = e;
    bus.req       = q;
    bus.burst_len = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] s, input logic v,
                            input logic [6:0] g, input logic l);
    check({tag, "_sel"},     32'(bus.sel),     32'(s));
    check({tag, "_sel_val"}, 32'(bus.sel_val), 32'(v));
    check({tag, "_grant"},   32'(bus.grant),   32'(g));
    check({tag, "_last"},    32'(bus.last),    32'(l));
  endtask

  initial begin
    reset = 1'b1; bus.en = 1'b0; bus.req = '0; bus.burst_len = '0;

    // rst en  req    bl     sel   val   grant  last
    vecs[0]  = '{1'b1, 1'b0, 7'h00, 4'd0, 3'd0, 1'b0, 7'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 7'h01, 4'd0, 3'd0, 1'b1, 7'h01, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 7'h01, 4'd0, 3'd0, 1'b1, 7'h01, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 7'h01, 4'd0, 3'd0, 1'b1, 7'h01, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 7'h01, 4'd0, 3'd0, 1'b0, 7'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 7'h41, 4'd2, 3'd0, 1'b1, 7'h01, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 7'h41, 4'd2, 3'd0, 1'b1, 7'h01, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 7'h41, 4'd2, 3'd0, 1'b1, 7'h01, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 7'h41, 4'd2, 3'd6, 1'b1, 7'h40, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 7'h41, 4'd2, 3'd6, 1'b1, 7'h40, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 7'h41, 4'd2, 3'd6, 1'b1, 7'h40, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 7'h41, 4'd2, 3'd0, 1'b1, 7'h01, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 7'h41, 4'd2, 3'd0, 1'b1, 7'h01, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 7'h41, 4'd2, 3'd0, 1'b1, 7'h01, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 7'h41, 4'd2, 3'd6, 1'b1, 7'h40, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 7'h7F, 4'd2, 3'd6, 1'b1, 7'h40, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 7'h7F, 4'd2, 3'd6, 1'b1, 7'h40, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 7'h7F, 4'd0, 3'd0, 1'b1, 7'h01, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 7'h7F, 4'd0, 3'd1, 1'b1, 7'h02, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 7'h7F, 4'd0, 3'd2, 1'b1, 7'h04, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 7'h7F, 4'd0, 3'd2, 1'b0, 7'h00, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 7'h7F, 4'd0, 3'd2, 1'b0, 7'h00, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 7'h00, 4'd0, 3'd2, 1'b0, 7'h00, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 7'h08, 4'd1, 3'd3, 1'b1, 7'h08, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 7'h08, 4'd5, 3'd3, 1'b1, 7'h08, 1'b1};
    vecs[25] = '{1'b0, 1'b1, 7'h08, 4'd5, 3'd3, 1'b1, 7'h08, 1'b0};
    vecs[26] = '{1'b0, 1'b1, 7'h08, 4'd5, 3'd3, 1'b1, 7'h08, 1'b0};
    vecs[27] = '{1'b0, 1'b1, 7'h08, 4'd5, 3'd3, 1'b1, 7'h08, 1'b0};
    vecs[28] = '{1'b0, 1'b1, 7'h08, 4'd5, 3'd3, 1'b1, 7'h08, 1'b0};
    vecs[29] = '{1'b0, 1'b1, 7'h08, 4'd5, 3'd3, 1'b1, 7'h08, 1'b0};
    vecs[30] = '{1'b0, 1'b1, 7'h08, 4'd5, 3'd3, 1'b1, 7'h08, 1'b1};
    vecs[31] = '{1'b0, 1'b0, 7'h08, 4'd5, 3'd3, 1'b0, 7'h00, 1'b0};

    for (int i = 0; i < 32; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].bl);
      expect_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].val, vecs[i].grant, vecs[i].last);
    end

    // Enable falls during a 4-cycle burst on lane 2; the burst still completes.
    drive(1'b1, 1'b0, 7'h00, 4'd0);
    expect_out("endrop_rst", 3'd0, 1'b0, 7'h00, 1'b0);
    drive(1'b0, 1'b1, 7'h04, 4'd3);
    expect_out("endrop_c1", 3'd2, 1'b1, 7'h04, 1'b0);
    drive(1'b0, 1'b0, 7'h04, 4'd3);
    expect_out("endrop_c2", 3'd2, 1'b1, 7'h04, 1'b0);
    drive(1'b0, 1'b0, 7'h04, 4'd3);
    expect_out("endrop_c3", 3'd2, 1'b1, 7'h04, 1'b0);
    drive(1'b0, 1'b0, 7'h04, 4'd3);
    expect_out("endrop_c4", 3'd2, 1'b1, 7'h04, 1'b1);
    drive(1'b0, 1'b0, 7'h04, 4'd3);
    expect_out("endrop_idle", 3'd2, 1'b0, 7'h00, 1'b0);

    // Reset on the second cycle of a lane-6 burst, then the pointer restarts at lane 0.
    drive(1'b0, 1'b1, 7'h40, 4'd3);
    expect_out("rstmid_c1", 3'd6, 1'b1, 7'h40, 1'b0);
    drive(1'b0, 1'b1, 7'h40, 4'd3);
    expect_out("rstmid_c2", 3'd6, 1'b1, 7'h40, 1'b0);
    drive(1'b1, 1'b1, 7'h40, 4'd3);
    expect_out("rstmid_rst", 3'd0, 1'b0, 7'h00, 1'b0);
    drive(1'b0, 1'b1, 7'h06, 4'd0);
    expect_out("rstmid_regrant", 3'd1, 1'b1, 7'h02, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lane_grant_scheduler.md
LANE_GRANT_SCHEDULER -- requirements
Module: lane_grant_scheduler

Interface
REQ-001 Parameter: LEN_W, default 4, width of burst_len.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 en  input  1  scheduler enable; gates the start of new bursts only.
REQ-005 req  input  7  per-lane request levels, lanes 0..6.
REQ-006 burst_len  input  LEN_W  burst length minus one; a burst lasts burst_len+1 cycles.
REQ-007 sel  output  3  index of the granted lane, 0..6, registered.
REQ-008 sel_val  output  1  grant active, registered.
REQ-009 grant  output  7  one-hot of sel when sel_val=1; all-zero when sel_val=0.
REQ-010 last  output  1  high on the final cycle of a burst, registered.

Function
REQ-011 The block SHALL have two states: IDLE and BURST.
REQ-012 The block SHALL hold an internal 3-bit round-robin pointer ptr, range 0..6, marking the highest-priority lane.
REQ-013 Arbitration SHALL pick the first lane with req=1, scanning ptr, ptr+1, … with 6 wrapping to 0; sel SHALL never be 7.
REQ-014 In IDLE with en=1 and |req=1 in cycle t, the block SHALL enter BURST at t+1. At t+1: sel=winner, sel_val=1, and the internal counter SHALL equal burst_len sampled at t.
REQ-015 In IDLE with en=0 or req=0, the block SHALL stay in IDLE with sel_val=0, grant=0 and last=0; sel SHALL hold its value.
REQ-016 In BURST, the counter SHALL decrement by 1 each cycle; last SHALL be 1 exactly when the counter is 0.
REQ-017 burst_len SHALL be sampled only when a winner is chosen; changes during a burst SHALL be ignored.
REQ-018 A burst SHALL run to completion regardless of req[sel] or en changes during it (no abort).
REQ-019 On the last cycle of a burst, ptr SHALL update to sel+1, with 6 wrapping to 0.
REQ-020 On the last cycle of a burst, arbitration SHALL use the updated pointer value (sel+1 wrapped) to choose the next winner.
REQ-021 On that last cycle, if en=1 and |req=1, the next burst SHALL start in the following cycle with no bubble (sel_val stays 1).
REQ-022 On that last cycle, if en=0 or req=0, the block SHALL enter IDLE and sel_val SHALL be 0 in the next cycle.
REQ-023 When only the current lane requests, it SHALL be regranted back-to-back.
REQ-024 grant SHALL equal (1 << sel) gated by sel_val; it SHALL be derived from registered sel and sel_val with no combinational path from req.

Reset
REQ-025 With reset=1 at a rising edge, the next cycle SHALL have state=IDLE, ptr=0, counter=0, sel=0, sel_val=0, grant=0, last=0.
REQ-026 Reset SHALL take priority over every other input, including during BURST.
REQ-027 The first arbitration after reset SHALL scan from lane 0.

Verification
REQ-028 Single lane: reset, then en=1, req=0000001, burst_len=0 -> from the next cycle on, every cycle shows sel=0, grant=0000001, sel_val=1, last=1.
REQ-029 Two lanes: req=1000001, burst_len=2 -> lane 0 for 3 cycles, then lane 6 for 3 cycles, then lane 0 again; no bubbles; last=1 on every 3rd cycle.
REQ-030 Wrap-around: a burst on lane 6 completes with req=1111111 -> next grant is sel=0, grant=0000001.
REQ-031 Enable drop: en falls to 0 mid-burst (burst_len=3) -> the remaining cycles complete with last=1 on the 4th; the next cycle has sel_val=0 and grant=0.
REQ-032 Length change: burst_len changes from 1 to 5 mid-burst -> the current burst still lasts 2 cycles; the next burst lasts 6.
REQ-033 Reset mid-burst: reset asserted on burst cycle 2 -> all outputs are 0 in the next cycle; after release with req=0000110, the grant goes to lane 1.
